rv32v_dmem_arbiter: RTL

Shares the single data-memory generic bus between the scalar load/store path and the vector memory serializer in the stage4 memory stage. It arbitrates between the two requesters, registers the winning request, and drives it onto the bus until the transaction completes. It routes the response back to the requester that owns it. It also holds the bus for the vector serializer across the lanes of one vector uop, with a starvation limit that protects the scalar path.

---
 rtl/rv32v_types_pkg.sv | 23 ++
 rtl/rv32v_dmem_arb_perf.sv | 26 ++
 rtl/rv32v_dmem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v memory stage: data-memory arbiter state, request payload and widths.
package rv32v_types_pkg;

  localparam int unsigned ARB_STARVE_W = 8;
  localparam int unsigned ARB_XLEN     = 32;
  localparam int unsigned ARB_BE_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_S = 2'd1,
    ISSUE_V = 2'd2,
    LOCKED  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                  ren;
    logic                  wen;
    logic [ARB_XLEN-1:0]   addr;
    logic [ARB_XLEN-1:0]   wdata;
    logic [ARB_BE_W-1:0]   byte_en;
  } arb_req_t;

endpackage

// File: rtl/rv32v_dmem_arb_perf.sv
// Grant and scalar-stall event counters for the data-memory arbiter (used under RV32V_DMEM_ARB_PERF_EN).
module rv32v_dmem_arb_perf (
  input  logic        CLK,
  input  logic        RST,
  input  logic        s_grant,
  input  logic        v_grant,
  input  logic        s_stall,
  output logic [31:0] perf_s_grants,
  output logic [31:0] perf_v_grants,
  output logic [31:0] perf_s_stall_cycles
);

  // Free-running counters, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_s_grants       <= '0;
      perf_v_grants       <= '0;
      perf_s_stall_cycles <= '0;
    end else begin
      if (s_grant) perf_s_grants       <= perf_s_grants + 32'(1);
      if (v_grant) perf_v_grants       <= perf_v_grants + 32'(1);
      if (s_stall) perf_s_stall_cycles <= perf_s_stall_cycles + 32'(1);
    end
  end

endmodule

// File: rtl/rv32v_dmem_arbiter.sv
// Scalar/vector arbiter for the shared data-memory bus with vector bus locking and scalar starvation guard.
// Optional performance counters are enabled by defining RV32V_DMEM_ARB_PERF_EN.
module rv32v_dmem_arbiter
  import rv32v_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                s_ren,
  input  logic                s_wen,
  input  logic [31:0]         s_addr,
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_byte_en,
  output logic                s_busy,
  output logic [31:0]         s_rdata,
  output logic                s_error,
  input  logic                v_ren,
  input  logic                v_wen,
  input  logic [31:0]         v_addr,
  input  logic [31:0]         v_wdata,
  input  logic [3:0]          v_byte_en,
  input  logic                v_lock,
  output logic                v_busy,
  output logic [31:0]         v_rdata,
  output logic                v_error,
  output logic                bus_ren,
  output logic                bus_wen,
  output logic [31:0]         bus_addr,
  output logic [31:0]         bus_wdata,
  output logic [3:0]          bus_byte_en,
  input  logic                bus_busy,
  input  logic [31:0]         bus_rdata,
  input  logic                bus_error
`ifdef RV32V_DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_s_grants,
  output logic [31:0]         perf_v_grants,
  output logic [31:0]         perf_s_stall_cycles
`endif
);

  localparam logic [ARB_STARVE_W-1:0] LIMIT      = ARB_STARVE_W'(STARVE_LIMIT);
  localparam logic [ARB_STARVE_W-1:0] STARVE_MAX = '1;

  arb_state_t               state_q;
  arb_req_t                 req_q;
  arb_req_t                 s_pkt;
  arb_req_t                 v_pkt;
  logic [ARB_STARVE_W-1:0]  starve_q;
  logic [ARB_STARVE_W-1:0]  starve_d;
  logic                     s_req;
  logic                     v_req;
  logic                     starved;
  logic                     s_latch;
  logic                     v_latch;
  logic                     s_wait;
  logic                     s_done;
  logic                     v_done;

  assign s_req = s_ren | s_wen;
  assign v_req = v_ren | v_wen;
  assign s_pkt = '{ren: s_ren, wen: s_wen, addr: s_addr, wdata: s_wdata, byte_en: s_byte_en};
  assign v_pkt = '{ren: v_ren, wen: v_wen, addr: v_addr, wdata: v_wdata, byte_en: v_byte_en};

  // Grant decisions; a starved scalar overrides both vector priority and the lock.
  always_comb begin
    starved  = (starve_q >= LIMIT);
    s_latch  = (state_q == IDLE) && s_req && (starved || !v_req);
    v_latch  = v_req && (((state_q == IDLE) && !(starved && s_req)) ||
                         ((state_q == LOCKED) && !starved));
    s_wait   = s_req && !s_latch && (state_q != ISSUE_S);
    starve_d = starve_q;
    if (s_latch) begin
      starve_d = '0;
    end else if (s_wait && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + ARB_STARVE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      req_q    <= '0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (v_latch) begin
            req_q   <= v_pkt;
            state_q <= ISSUE_V;
          end else if (s_latch) begin
            req_q   <= s_pkt;
            state_q <= ISSUE_S;
          end
        end
        ISSUE_S: begin
          if (!bus_busy) begin
            req_q   <= '0;
            state_q <= IDLE;
          end
        end
        ISSUE_V: begin
          if (!bus_busy) begin
            req_q   <= '0;
            state_q <= (v_lock && !starved) ? LOCKED : IDLE;
          end
        end
        LOCKED: begin
          if (v_latch) begin
            req_q   <= v_pkt;
            state_q <= ISSUE_V;
          end else if (starved || !v_lock) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response routing: only a still-requesting owner sees the completion.
  assign s_done  = (state_q == ISSUE_S) && !bus_busy && s_req;
  assign v_done  = (state_q == ISSUE_V) && !bus_busy && v_req;
  assign s_busy  = s_req && !s_done;
  assign v_busy  = v_req && !v_done;
  assign s_rdata = s_done ? bus_rdata : '0;
  assign v_rdata = v_done ? bus_rdata : '0;
  assign s_error = s_done && bus_error;
  assign v_error = v_done && bus_error;

  assign bus_ren     = req_q.ren;
  assign bus_wen     = req_q.wen;
  assign bus_addr    = req_q.addr;
  assign bus_wdata   = req_q.wdata;
  assign bus_byte_en = req_q.byte_en;

`ifdef RV32V_DMEM_ARB_PERF_EN
  rv32v_dmem_arb_perf u_perf (
    .CLK                 (CLK),
    .RST                 (RST),
    .s_grant             (s_latch),
    .v_grant             (v_latch),
    .s_stall             (s_wait),
    .perf_s_grants       (perf_s_grants),
    .perf_v_grants       (perf_v_grants),
    .perf_s_stall_cycles (perf_s_stall_cycles)
  );
`endif

endmodule
